// File: rtl/cpu_control_unit_if.sv
// Bundle between the control unit and its neighbours: fetched instruction and live ALU flags in,
// decoded fields, datapath controls, architectural flags and status out.
interface cpu_control_unit_if #(
  parameter int RET_W = 32
);
  logic [31:0]      Instr;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic [4:0]       Rn;
  logic [4:0]       Rm;
  logic [4:0]       Rd;
  logic [5:0]       Shamt;
  logic [11:0]      Imm12;
  logic [8:0]       Imm9;
  logic [25:0]      Imm26;
  logic [18:0]      Imm19;
  logic             RegWrite;
  logic             ShiftControl;
  logic             Reg2Loc;
  logic             LDUR_STUR;
  logic             ALUsrc;
  logic             MemRead;
  logic             MemWrite;
  logic             MemToReg;
  logic             UncondiBr;
  logic             Brtaken;
  logic [2:0]       ALUControl;
  logic [3:0]       xfer_size;
  logic [3:0]       flags_q;
  logic             halted;
  logic [RET_W-1:0] retired;

  modport master (
    input  Instr, negative, zero, overflow, carry_out,
    output Rn, Rm, Rd, Shamt, Imm12, Imm9, Imm26, Imm19,
           RegWrite, ShiftControl, Reg2Loc, LDUR_STUR, ALUsrc, MemRead, MemWrite, MemToReg,
           UncondiBr, Brtaken, ALUControl, xfer_size, flags_q, halted, retired
  );

  modport slave (
    output Instr, negative, zero, overflow, carry_out,
    input  Rn, Rm, Rd, Shamt, Imm12, Imm9, Imm26, Imm19,
           RegWrite, ShiftControl, Reg2Loc, LDUR_STUR, ALUsrc, MemRead, MemWrite, MemToReg,
           UncondiBr, Brtaken, ALUControl, xfer_size, flags_q, halted, retired
  );
endinterface

// File: rtl/cpu_control_unit.sv
// LEGv8 decoder/sequencer: combinational decode of the current instruction, NZVC flag register,
// retired-instruction counter, and a RUN/HALT FSM that freezes the PC on an illegal opcode.
module cpu_control_unit #(
  parameter int RET_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  cpu_control_unit_if.master bus
);

  typedef enum logic {RUN, HALT} state_e;

  state_e           state_q;
  logic             halted_q;
  logic [3:0]       flags_q;
  logic [RET_W-1:0] retired_q;

  logic [31:0] instr;
  logic [10:0] op11;
  logic is_addi, is_adds, is_subs, is_and, is_eor, is_lsr;
  logic is_ldur, is_stur, is_b, is_blt, is_cbz, legal, run_legal;

  assign instr   = bus.Instr;
  assign op11    = instr[31:21];
  assign is_addi = (instr[31:22] == 10'b1001000100);
  assign is_adds = (op11 == 11'b10101011000);
  assign is_subs = (op11 == 11'b11101011000);
  assign is_and  = (op11 == 11'b10001010000);
  assign is_eor  = (op11 == 11'b11001010000);
  assign is_lsr  = (op11 == 11'b11010011010);
  assign is_ldur = (op11 == 11'b11111000010);
  assign is_stur = (op11 == 11'b11111000000);
  assign is_b    = (instr[31:26] == 6'b000101);
  // Only the LT condition is implemented; any other B.cond is treated as illegal.
  assign is_blt  = (instr[31:24] == 8'b01010100) && (instr[4:0] == 5'b01011);
  assign is_cbz  = (instr[31:24] == 8'b10110100);
  assign legal   = is_addi | is_adds | is_subs | is_and | is_eor | is_lsr |
                   is_ldur | is_stur | is_b | is_blt | is_cbz;
  assign run_legal = (state_q == RUN) && legal;

  logic       reg_write, shift_ctl, reg2loc, ldur_stur, alu_src;
  logic       mem_read, mem_write, mem_to_reg, uncond_br, br_taken;
  logic [2:0] alu_ctl;
  logic [3:0] xfer;
  logic [25:0] imm26;

  always_comb begin
    reg_write  = 1'b0;
    shift_ctl  = 1'b0;
    reg2loc    = 1'b0;
    ldur_stur  = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    uncond_br  = 1'b0;
    br_taken   = 1'b0;
    alu_ctl    = 3'b000;
    xfer       = 4'b0000;
    imm26      = instr[25:0];
    if (!run_legal) begin
      // Branch-to-self with zero offset keeps the PC parked on the offending word.
      uncond_br = 1'b1;
      br_taken  = 1'b1;
      imm26     = '0;
    end else if (is_addi) begin
      reg_write = 1'b1;
      alu_src   = 1'b1;
      alu_ctl   = 3'b010;
    end else if (is_adds || is_subs) begin
      reg_write = 1'b1;
      reg2loc   = 1'b1;
      alu_ctl   = is_adds ? 3'b010 : 3'b011;
    end else if (is_and || is_eor) begin
      reg_write = 1'b1;
      reg2loc   = 1'b1;
      alu_ctl   = is_and ? 3'b100 : 3'b110;
    end else if (is_lsr) begin
      reg_write = 1'b1;
      shift_ctl = 1'b1;
    end else if (is_ldur || is_stur) begin
      reg_write  = is_ldur;
      mem_read   = is_ldur;
      mem_to_reg = is_ldur;
      mem_write  = is_stur;
      alu_src    = 1'b1;
      ldur_stur  = 1'b1;
      alu_ctl    = 3'b010;
      xfer       = 4'b1000;
    end else if (is_b) begin
      uncond_br = 1'b1;
      br_taken  = 1'b1;
    end else if (is_blt) begin
      br_taken = flags_q[3] ^ flags_q[1];
    end else if (is_cbz) begin
      br_taken = bus.zero;
    end
    if (reset) begin
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      halted_q  <= 1'b0;
      flags_q   <= 4'b0000;
      retired_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (!legal) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            retired_q <= retired_q + 1'b1;
            if (is_adds || is_subs)
              flags_q <= {bus.negative, bus.zero, bus.overflow, bus.carry_out};
          end
        end
        default: begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Rn           = instr[9:5];
  assign bus.Rm           = instr[20:16];
  assign bus.Rd           = instr[4:0];
  assign bus.Shamt        = instr[15:10];
  assign bus.Imm12        = instr[21:10];
  assign bus.Imm9         = instr[20:12];
  assign bus.Imm19        = instr[23:5];
  assign bus.Imm26        = imm26;
  assign bus.RegWrite     = reg_write;
  assign bus.ShiftControl = shift_ctl;
  assign bus.Reg2Loc      = reg2loc;
  assign bus.LDUR_STUR    = ldur_stur;
  assign bus.ALUsrc       = alu_src;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.MemToReg     = mem_to_reg;
  assign bus.UncondiBr    = uncond_br;
  assign bus.Brtaken      = br_taken;
  assign bus.ALUControl   = alu_ctl;
  assign bus.xfer_size    = xfer;
  assign bus.flags_q      = flags_q;
  assign bus.halted       = halted_q;
  assign bus.retired      = retired_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: the driver pushes per-cycle expectations from a table-driven
// reference model; a negedge monitor pops them and compares against the DUT outputs.
module tb_cpu_control_unit;
  localparam int RET_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_control_unit_if #(.RET_W(RET_W)) bus ();
  cpu_control_unit #(.RET_W(RET_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR, K_LSR, K_LDUR, K_STUR,
                    K_B, K_BLT, K_CBZ, K_ILL} kind_e;

  logic [31:0] pat_mask  [0:10] = '{32'hFFC00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000,
                                    32'hFFE00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000,
                                    32'hFC000000, 32'hFF00001F, 32'hFF000000};
  logic [31:0] pat_match [0:10] = '{32'h91000000, 32'hAB000000, 32'hEB000000, 32'h8A000000,
                                    32'hCA000000, 32'hD3400000, 32'hF8400000, 32'hF8000000,
                                    32'h14000000, 32'h5400000B, 32'hB4000000};

  typedef struct packed {
    logic [16:0]      ctl;
    logic [25:0]      imm26;
    logic [60:0]      fields;
    logic [3:0]       flags;
    logic             halted;
    logic [RET_W-1:0] ret;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic             m_halt;
  logic [3:0]       m_flags;
  logic [RET_W-1:0] m_ret;

  function automatic kind_e classify(input logic [31:0] w);
    for (int i = 0; i < 11; i++)
      if ((w & pat_mask[i]) == pat_match[i]) return kind_e'(i);
    return K_ILL;
  endfunction

  function automatic logic [31:0] gen_legal();
    int k;
    k = $urandom_range(0, 10);
    return pat_match[k] | ($urandom & ~pat_mask[k]);
  endfunction

  function automatic logic [31:0] gen_illegal();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      if (classify(w) == K_ILL) return w;
    end
    return 32'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one instruction for one cycle, record what the outputs must be, advance the model.
  task automatic step(input logic [31:0] w, input logic [3:0] nzvc, input logic rst);
    exp_t  e;
    kind_e k;
    logic  rw, sc, r2l, ls, asrc, mr, mw, m2r, ub, bt;
    logic [2:0] alu;
    logic [3:0] xs;
    reset = rst;
    bus.Instr = w;
    {bus.negative, bus.zero, bus.overflow, bus.carry_out} = nzvc;
    k = classify(w);
    {rw, sc, r2l, ls, asrc, mr, mw, m2r, ub, bt} = '0;
    alu = 3'b000;
    xs  = 4'b0000;
    e = '0;
    e.imm26  = w[25:0];
    e.fields = {w[9:5], w[20:16], w[4:0], w[15:10], w[21:10], w[20:12], w[23:5]};
    e.flags  = m_flags;
    e.halted = m_halt;
    e.ret    = m_ret;
    if (m_halt || k == K_ILL) begin
      ub = 1'b1; bt = 1'b1; e.imm26 = '0;
    end else begin
      case (k)
        K_ADDI: begin rw = 1; asrc = 1; alu = 3'b010; end
        K_ADDS: begin rw = 1; r2l = 1; alu = 3'b010; end
        K_SUBS: begin rw = 1; r2l = 1; alu = 3'b011; end
        K_AND:  begin rw = 1; r2l = 1; alu = 3'b100; end
        K_EOR:  begin rw = 1; r2l = 1; alu = 3'b110; end
        K_LSR:  begin rw = 1; sc = 1; end
        K_LDUR: begin rw = 1; asrc = 1; ls = 1; alu = 3'b010; mr = 1; m2r = 1; xs = 4'b1000; end
        K_STUR: begin mw = 1; asrc = 1; ls = 1; alu = 3'b010; xs = 4'b1000; end
        K_B:    begin ub = 1; bt = 1; end
        K_BLT:  bt = (m_flags[3] != m_flags[1]);
        K_CBZ:  bt = nzvc[2];
        default: ;
      endcase
    end
    if (rst) begin rw = 0; mw = 0; mr = 0; end
    e.ctl = {rw, sc, r2l, ls, asrc, mr, mw, m2r, ub, bt, alu, xs};
    q.push_back(e);
    if (rst) begin
      m_halt = 1'b0; m_flags = 4'b0000; m_ret = '0;
    end else if (!m_halt) begin
      if (k == K_ILL) m_halt = 1'b1;
      else begin
        m_ret = m_ret + 1'b1;
        if (k == K_ADDS || k == K_SUBS) m_flags = nzvc;
      end
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctl", 64'({bus.RegWrite, bus.ShiftControl, bus.Reg2Loc, bus.LDUR_STUR, bus.ALUsrc,
                      bus.MemRead, bus.MemWrite, bus.MemToReg, bus.UncondiBr, bus.Brtaken,
                      bus.ALUControl, bus.xfer_size}), 64'(e.ctl));
      chk("imm26", 64'(bus.Imm26), 64'(e.imm26));
      chk("fields", 64'({bus.Rn, bus.Rm, bus.Rd, bus.Shamt, bus.Imm12, bus.Imm9, bus.Imm19}),
          64'(e.fields));
      chk("flags_q", 64'(bus.flags_q), 64'(e.flags));
      chk("halted", 64'(bus.halted), 64'(e.halted));
      chk("retired", 64'(bus.retired), 64'(e.ret));
    end
  end

  localparam logic [31:0] ADDI5 = {10'b1001000100, 12'd5, 5'd31, 5'd1};
  localparam logic [31:0] SUBS1 = 32'hEB020020;
  localparam logic [31:0] BLT4  = {8'h54, 19'd4, 5'b01011};
  localparam logic [31:0] CBZ1  = 32'hB4000083;
  localparam logic [31:0] STUR1 = 32'hF8010022;

  initial begin
    int halt_cnt;
    reset = 1'b1;
    bus.Instr = 32'h0;
    {bus.negative, bus.zero, bus.overflow, bus.carry_out} = 4'b0000;
    m_halt = 1'b0; m_flags = 4'b0000; m_ret = '0;
    @(posedge clk); #1;
    // Reset, then ADDI; retired increments across the following edge.
    step(ADDI5, 4'b0000, 1'b1);
    step(ADDI5, 4'b0000, 1'b0);
    step(ADDI5, 4'b0000, 1'b0);
    // SUBS N=1,V=0 then taken B.LT.
    step(SUBS1, 4'b1000, 1'b0);
    step(BLT4,  4'b0011, 1'b0);
    // SUBS N=1,V=1, ADDI leaves flags alone, B.LT not taken.
    step(SUBS1, 4'b1010, 1'b0);
    step(ADDI5, 4'b0101, 1'b0);
    step(BLT4,  4'b0000, 1'b0);
    // CBZ on the live zero flag.
    step(CBZ1, 4'b0100, 1'b0);
    step(CBZ1, 4'b0000, 1'b0);
    // Illegal opcode halts; reset recovers.
    step(32'h0, 4'b1111, 1'b0);
    step(32'h0, 4'b1111, 1'b0);
    step(ADDI5, 4'b1111, 1'b0);
    step(SUBS1, 4'b0101, 1'b0);
    step(32'h0, 4'b0000, 1'b1);
    step(ADDI5, 4'b0000, 1'b0);
    // Counter wrap at 2^RET_W, then STUR.
    step(ADDI5, 4'b0000, 1'b1);
    for (int i = 0; i < 17; i++) step(gen_legal(), 4'($urandom), 1'b0);
    step(STUR1, 4'b0000, 1'b0);
    // Randomized run with occasional illegal words and resets.
    halt_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      logic        r;
      w = ($urandom_range(0, 39) == 0) ? gen_illegal() : gen_legal();
      r = ($urandom_range(0, 59) == 0);
      if (m_halt) begin
        halt_cnt++;
        if (halt_cnt >= 3) begin r = 1'b1; halt_cnt = 0; end
      end
      step(w, 4'($urandom), r);
    end
    @(negedge clk); #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
